apb_reg_arbiter: RTL
====================

Name: apb_reg_arbiter

Overview:
- APB-style master and two-requester round-robin arbiter in front of the 8-bit register slave (cntrl, reg1..reg4; word index = paddr[4:2]).
- Accepts one read/write command at a time from either requester, runs a SETUP/ACCESS sequence on the slave bus, and returns read data with a requester ID.
- Keeps pwrite low outside write transfers, because the slave has no psel qualification and writes on every cycle that pwrite is high.

Parameters:
ADDR_W, 5, slave address width (paddr)
DATA_W, 8, slave data width
MAX_IDX, 4, highest mapped word index (paddr[4:2]); used only by the optional feature

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
req_valid  in  2  per-requester command valid, bit i = requester i
req_ready  out  2  per-requester accept; command transfers when valid&ready
req_write  in  2  per-requester 1 = write, 0 = read
req_addr  in  2*ADDR_W  per-requester address, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  2*DATA_W  per-requester write data, same packing
rsp_valid  out  1  one-cycle completion pulse
rsp_id  out  1  requester that owns the completion
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_err  out  1  decode error flag (0 when the optional feature is off)
psel  out  1  slave select
penable  out  1  access phase
pwrite  out  1  to slave pwrite
paddr  out  ADDR_W  to slave paddr
pwdata  out  DATA_W  to slave pwdata
prdata  in  DATA_W  from slave, registered inside the slave

Behaviour:
- FSM states: IDLE -> SETUP -> ACCESS -> RESP -> IDLE. Grants are issued only in IDLE. One transaction per 4 cycles.
- IDLE grant:
  - req_ready is combinational: req_ready[i] = valid[i] & (state == IDLE) & (granted i). At most one bit is set.
  - On transfer, latch id, write, addr and wdata, then go to SETUP.
- Arbitration:
  - Single requester valid: that requester wins.
  - Both valid: the requester not granted most recently wins.
  - The last-grant pointer updates only on transfer. After reset the pointer makes requester 0 win the first tie.
- SETUP: psel=1, penable=0; paddr/pwdata = latched values; pwrite = latched write. The slave writes its register, or loads prdata, at the end of this cycle.
- ACCESS: psel=1, penable=1; paddr/pwdata/pwrite held. At the end of the cycle, a read captures prdata into rsp_rdata; a write captures 0.
- RESP:
  - rsp_valid=1 for exactly one cycle, with rsp_id = latched id and rsp_rdata/rsp_err stable.
  - psel=0, penable=0, pwrite=0. Next state is IDLE.
- Outside SETUP/ACCESS: psel=0, penable=0, pwrite=0. paddr/pwdata hold their last driven values, which are harmless because the slave only reloads prdata.
- A requester may drop or change req_valid/payload freely while not accepted. Once accepted, its payload is no longer sampled.
- Reset values (asserted asynchronously, also mid-transaction):
  - state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
  - rsp_valid=0, rsp_id=0, rsp_rdata=0, rsp_err=0, last-grant pointer → requester 0 wins next tie.
  - An in-flight transaction is dropped with no response.
  - req_ready=0 while rst=0.
- Deassertion of rst is synchronised by the integrator; first grant is possible on the first edge with rst=1.

Optional Feature:
Macro: APB_ARB_DECODE_ERR_EN
- Defined: in IDLE, a transfer whose addr[4:2] > MAX_IDX is accepted normally, then skips SETUP/ACCESS and goes directly to RESP. No bus activity (psel, penable, pwrite stay 0). Response: rsp_err=1, rsp_rdata=0. Latency drops to 2 cycles.
- Undefined: no decode check. Unmapped addresses run the full bus sequence; the slave ignores them, and a read returns the stale prdata. rsp_err is tied to 0.

Test Plan:
- Write then read: requester 0 writes 0xA5 to addr 0x04, then reads 0x04 -> pwrite high only in SETUP/ACCESS of the write; read returns rsp_valid with rsp_id=0 and rsp_rdata=0xA5, 3 cycles after accept.
- Tie arbitration: both requesters hold valid; req0 writes 0x11 to 0x08, req1 writes 0x22 to 0x0C; reads follow -> grants alternate 0,1,0,1; rsp_id sequence matches; readback 0x08=0x11, 0x0C=0x22.
- Single requester streaming: only req1 valid for 4 commands -> req1 granted each time with no starvation gaps beyond 4-cycle spacing; psel low in every RESP/IDLE cycle.
- Reset mid-op: assert rst during ACCESS of a write of 0x5A to 0x10 -> psel, penable, pwrite, rsp_valid go 0 immediately; no response; after release a read of 0x10 returns 0x00.
- Decode error: read from addr 0x1C (index 7) -> with APB_ARB_DECODE_ERR_EN: rsp_err=1, rsp_rdata=0, psel never asserted, 2-cycle latency; without the macro: full SETUP/ACCESS seen, rsp_err=0.

Source files
------------

// File: rtl/apb_reg_arbiter.sv
// apb_reg_arbiter: two-requester round-robin front end and APB-style master
// for the 8-bit register slave (cntrl, reg1..reg4, word index = paddr[4:2]).
// Optional decode-error short-cut: define APB_ARB_DECODE_ERR_EN.
module apb_reg_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int MAX_IDX = 4
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W-1:0]     prdata
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

`ifdef APB_ARB_DECODE_ERR_EN
  localparam logic DEC_EN = 1'b1;
`else
  localparam logic DEC_EN = 1'b0;
`endif
  localparam logic [2:0] MAX_I = 3'(MAX_IDX);

  state_t              r_state, w_next;
  logic                r_last;     // requester granted most recently
  logic                r_id, r_write, r_err;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_rdata;

  logic                w_gnt_id, w_xfer, w_skip;
  logic [1:0]          w_ready;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_psel, w_pen, w_pwr;

  // Round-robin pick; ready only in IDLE and never while reset is asserted
  always_comb begin
    w_gnt_id = (req_valid == 2'b11) ? ~r_last : req_valid[1];
    w_ready  = 2'b00;
    if (rst && r_state == IDLE)
      w_ready = req_valid & (w_gnt_id ? 2'b10 : 2'b01);
    w_xfer   = |w_ready;
    w_addr   = w_gnt_id ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    w_wdata  = w_gnt_id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    // Unmapped index bypasses the bus only when the decode check is built in
    w_skip   = DEC_EN & (w_addr[4:2] > MAX_I);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next state and bus strobes; pwrite stays low outside SETUP/ACCESS since
  // the slave writes on any cycle with pwrite high
  always_comb begin
    w_next = r_state;
    w_psel = 1'b0;
    w_pen  = 1'b0;
    w_pwr  = 1'b0;
    case (r_state)
      IDLE:    if (w_xfer) w_next = w_skip ? RESP : SETUP;
      SETUP:   begin w_next = ACCESS; w_psel = 1'b1; w_pwr = r_write; end
      ACCESS:  begin w_next = RESP; w_psel = 1'b1; w_pen = 1'b1; w_pwr = r_write; end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Command latch on transfer and read-data capture at the end of ACCESS
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last  <= 1'b1;  // makes requester 0 win the first tie
      r_id    <= 1'b0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else if (w_xfer) begin
      r_last  <= w_gnt_id;
      r_id    <= w_gnt_id;
      r_write <= req_write[w_gnt_id];
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_err   <= w_skip;
      if (w_skip) r_rdata <= '0;
    end else if (r_state == ACCESS) begin
      r_rdata <= r_write ? '0 : prdata;
    end
  end

  assign req_ready = w_ready;
  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_id;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign psel      = w_psel;
  assign penable   = w_pen;
  assign pwrite    = w_pwr;
  assign paddr     = r_addr;
  assign pwdata    = r_wdata;

endmodule
